// File: rtl/aluop_instr_encoder.sv
// aluop_instr_encoder
// Turns an ALU operation code plus operands into an RV32I OP (R-type) or
// OP-IMM (I-type) instruction word. Words are queued in a small FIFO, each
// tagged with an instruction-memory word address. Illegal requests are still
// queued as a NOP with an error flag and do not consume an address.
//
// ALU operation codes (mirrors the ALU_* constants of the decode path):
//   0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 OR, 8 AND
module aluop_instr_encoder #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [3:0]                    in_alu_op,
  input  logic                          in_is_imm,
  input  logic                          in_arith,
  input  logic [4:0]                    in_rd,
  input  logic [4:0]                    in_rs1,
  input  logic [4:0]                    in_rs2,
  input  logic signed [11:0]            in_imm,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [31:0]                   out_instr,
  output logic [ADDR_W-1:0]             out_addr,
  output logic                          out_err,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_OR   = 4'd7;
  localparam logic [3:0] ALU_AND  = 4'd8;

  localparam logic [6:0]  OPC_OP     = 7'b0110011;
  localparam logic [6:0]  OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0]  F7_ALT     = 7'b0100000;
  localparam logic [31:0] NOP_WORD   = 32'h0000_0013;

  function automatic logic [2:0] funct3_of(input logic [3:0] op);
    logic [2:0] f3;
    f3 = 3'b000;
    case (op)
      ALU_ADD, ALU_SUB: f3 = 3'b000;
      ALU_SLL:          f3 = 3'b001;
      ALU_SLT:          f3 = 3'b010;
      ALU_SLTU:         f3 = 3'b011;
      ALU_XOR:          f3 = 3'b100;
      ALU_SRL:          f3 = 3'b101;
      ALU_OR:           f3 = 3'b110;
      ALU_AND:          f3 = 3'b111;
      default:          f3 = 3'b000;
    endcase
    return f3;
  endfunction

  function automatic logic is_legal(input logic [3:0] op, input logic is_imm);
    return (op <= ALU_AND) && !(op == ALU_SUB && is_imm);
  endfunction

  function automatic logic [31:0] encode(
    input logic [3:0]  op,
    input logic        is_imm,
    input logic        arith,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [11:0] imm
  );
    logic [6:0]  f7;
    logic [11:0] imm_f;
    logic [2:0]  f3;
    f3    = funct3_of(op);
    f7    = ((op == ALU_SUB) || (op == ALU_SRL && arith)) ? F7_ALT : 7'b0000000;
    imm_f = imm;
    // Shift immediates carry only a 5-bit shamt; the upper field is funct7.
    if (op == ALU_SLL || op == ALU_SRL)
      imm_f = {f7, imm[4:0]};
    if (is_imm)
      return {imm_f, rs1, f3, rd, OPC_OP_IMM};
    return {f7, rs2, rs1, f3, rd, OPC_OP};
  endfunction

  logic [31:0]       instr_mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] addr_mem  [FIFO_DEPTH];
  logic              err_mem   [FIFO_DEPTH];

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [LVL_W-1:0]  count;
  logic [ADDR_W-1:0] addr_cnt;
  logic              ready_en;

  logic              legal_p0;
  logic [31:0]       instr_p0;
  logic              full;
  logic              push;
  logic              pop;

  // Request encode stage: word and legality derived straight from the inputs
  always_comb begin
    legal_p0 = is_legal(in_alu_op, in_is_imm);
    instr_p0 = legal_p0 ? encode(in_alu_op, in_is_imm, in_arith, in_rd, in_rs1,
                                 in_rs2, in_imm)
                        : NOP_WORD;
  end

  assign full      = (count == LVL_W'(FIFO_DEPTH));
  assign in_ready  = ready_en && !full;
  assign push      = in_valid && in_ready;
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign level     = count;

  // Head is gated by out_valid so an empty or resetting FIFO shows zeros
  assign out_instr = out_valid ? instr_mem[rd_ptr] : '0;
  assign out_addr  = out_valid ? addr_mem[rd_ptr]  : '0;
  assign out_err   = out_valid ? err_mem[rd_ptr]   : 1'b0;

  // FIFO storage stage: data written on accept, never reset
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr] <= instr_p0;
      addr_mem[wr_ptr]  <= addr_cnt;
      err_mem[wr_ptr]   <= !legal_p0;
    end
  end

  // Pointers, occupancy, address counter and the post-reset ready enable
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      addr_cnt <= '0;
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
        if (legal_p0)
          addr_cnt <= addr_cnt + ADDR_W'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + LVL_W'(1);
        2'b01:   count <= count - LVL_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_aluop_instr_encoder.sv
// Self-checking bench for aluop_instr_encoder: expected words are queued when
// a request is accepted and compared as the FIFO head is consumed.
module tb_aluop_instr_encoder;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SLL  = 4'd2;
  localparam logic [3:0] OP_SLT  = 4'd3;
  localparam logic [3:0] OP_SLTU = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_OR   = 4'd7;
  localparam logic [3:0] OP_AND  = 4'd8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_alu_op = '0;
  logic        in_is_imm = 1'b0;
  logic        in_arith = 1'b0;
  logic [4:0]  in_rd = '0;
  logic [4:0]  in_rs1 = '0;
  logic [4:0]  in_rs2 = '0;
  logic signed [11:0] in_imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [7:0]  out_addr;
  logic        out_err;
  logic [2:0]  level;

  logic        in_valid2 = 1'b0;
  logic        in_ready2;
  logic [4:0]  in_rd2 = '0;
  logic        out_valid2;
  logic        out_ready2 = 1'b0;
  logic [31:0] out_instr2;
  logic [1:0]  out_addr2;
  logic        out_err2;
  logic [2:0]  level2;

  typedef struct {
    logic [31:0] instr;
    logic [7:0]  addr;
    logic        err;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] exp_addr = '0;
  int         n_cmp = 0;
  int         n_bad = 0;

  always #5 clk = ~clk;

  aluop_instr_encoder #(.FIFO_DEPTH(4), .ADDR_W(8)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_alu_op(in_alu_op),
    .in_is_imm(in_is_imm), .in_arith(in_arith), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_addr(out_addr), .out_err(out_err), .level(level)
  );

  aluop_instr_encoder #(.FIFO_DEPTH(4), .ADDR_W(2)) u_dut2 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_alu_op(OP_ADD),
    .in_is_imm(1'b1), .in_arith(1'b0), .in_rd(in_rd2),
    .in_rs1(5'd0), .in_rs2(5'd0), .in_imm(12'sd1),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_instr(out_instr2),
    .out_addr(out_addr2), .out_err(out_err2), .level(level2)
  );

  // Scoreboard: every consumed head is checked against the oldest expectation
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL sb_unexpected: got instr=%h addr=%0d with nothing expected",
                 out_instr, out_addr);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (out_instr !== e.instr || out_addr !== e.addr || out_err !== e.err) begin
          n_bad++;
          $display("FAIL sb_head: got instr=%h addr=%0d err=%b, want instr=%h addr=%0d err=%b",
                   out_instr, out_addr, out_err, e.instr, e.addr, e.err);
        end
      end
    end
  end

  task automatic send(input logic [3:0] op, input logic imm_f, input logic arith,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [11:0] imm, input logic [31:0] exp_instr,
                      input logic exp_err);
    bit accepted;
    exp_t e;
    in_valid  = 1'b1;
    in_alu_op = op;
    in_is_imm = imm_f;
    in_arith  = arith;
    in_rd     = rd;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_imm    = imm;
    accepted  = 1'b0;
    for (int c = 0; c < 20 && !accepted; c++) begin
      @(negedge clk);
      if (in_ready) begin
        e.instr = exp_instr;
        e.addr  = exp_addr;
        e.err   = exp_err;
        sb.push_back(e);
        if (!exp_err) exp_addr = exp_addr + 8'd1;
        @(posedge clk);
        #1;
        accepted = 1'b1;
      end
    end
    in_valid = 1'b0;
    if (!accepted) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: in_ready=%b, want 1 within 20 cycles", in_ready);
    end
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 50 && !done; c++) begin
      @(posedge clk);
      #1;
      if (sb.size() == 0 && !out_valid) done = 1'b1;
    end
    out_ready = 1'b0;
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: %0d entries left, out_valid=%b, want 0 and 0",
               sb.size(), out_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || level !== 3'd0 ||
        out_instr !== 32'h0 || out_addr !== 8'h0 || out_err !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state: valid=%b ready=%b level=%0d instr=%h addr=%0d err=%b, want all 0",
               out_valid, in_ready, level, out_instr, out_addr, out_err);
    end
    rst = 1'b0;
    exp_addr = '0;
    @(posedge clk);
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_release_ready: in_ready=%b, want 1", in_ready);
    end
  endtask

  task automatic test_single_add();
    send(OP_ADD, 1'b0, 1'b0, 5'd3, 5'd1, 5'd2, 12'h000, 32'h002081B3, 1'b0);
    n_cmp++;
    if (out_valid !== 1'b1 || out_instr !== 32'h002081B3 || out_addr !== 8'd0 ||
        out_err !== 1'b0 || level !== 3'd1) begin
      n_bad++;
      $display("FAIL single_add: valid=%b instr=%h addr=%0d err=%b level=%0d, want 1 002081b3 0 0 1",
               out_valid, out_instr, out_addr, out_err, level);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    send(OP_SUB, 1'b0, 1'b0, 5'd5, 5'd6, 5'd7, 12'h000, 32'h407302B3, 1'b0);
    send(OP_SRL, 1'b1, 1'b1, 5'd4, 5'd4, 5'd0, 12'h001, 32'h40125213, 1'b0);
    send(OP_ADD, 1'b1, 1'b0, 5'd1, 5'd0, 5'd0, 12'h005, 32'h00500093, 1'b0);
    send(OP_ADD, 1'b1, 1'b0, 5'd1, 5'd0, 5'd0, 12'hFFF, 32'hFFF00093, 1'b0);
    n_cmp++;
    if (level !== 3'd1) begin
      n_bad++;
      $display("FAIL b2b_level: level=%0d, want 1", level);
    end
    drain();
  endtask

  task automatic test_all_ops();
    logic [3:0]  ops  [14] = '{OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL,
                               OP_SRL, OP_OR, OP_AND, OP_ADD, OP_SLL, OP_SRL, OP_XOR};
    logic        immf [14] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1};
    logic        ar   [14] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 0, 0};
    logic [11:0] imms [14] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 12'hFE3, 12'hFFF, 12'h800};
    logic [31:0] want [14] = '{32'h003100B3, 32'h403100B3, 32'h003110B3, 32'h003120B3,
                               32'h003130B3, 32'h003140B3, 32'h003150B3, 32'h403150B3,
                               32'h003160B3, 32'h003170B3, 32'h003100B3, 32'h00311093,
                               32'h01F15093, 32'h80014093};
    out_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      send(ops[i], immf[i], ar[i], 5'd1, 5'd2, 5'd3, imms[i], want[i], 1'b0);
      n_cmp++;
      if (level !== 3'd1) begin
        n_bad++;
        $display("FAIL all_ops_level[%0d]: level=%0d, want 1", i, level);
      end
    end
    send(4'hF, 1'b0, 1'b0, 5'd1, 5'd2, 5'd3, 12'h000, 32'h00000013, 1'b1);
    drain();
  endtask

  task automatic test_full_stall();
    logic [31:0] head;
    exp_t e;
    out_ready = 1'b0;
    head = 32'h00000093;
    for (int i = 0; i < 4; i++)
      send(OP_ADD, 1'b1, 1'b0, 5'(i + 1), 5'd0, 5'd0, 12'(i),
           (32'(i) << 20) | (32'(i + 1) << 7) | 32'h13, 1'b0);
    n_cmp++;
    if (level !== 3'd4 || in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL full_level: level=%0d in_ready=%b, want 4 0", level, in_ready);
    end
    in_valid  = 1'b1;
    in_alu_op = OP_XOR;
    in_is_imm = 1'b0;
    in_arith  = 1'b0;
    in_rd     = 5'd1;
    in_rs1    = 5'd2;
    in_rs2    = 5'd3;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if (in_ready !== 1'b0 || level !== 3'd4 || out_instr !== head || out_valid !== 1'b1) begin
        n_bad++;
        $display("FAIL stall_hold[%0d]: ready=%b level=%0d instr=%h valid=%b, want 0 4 %h 1",
                 c, in_ready, level, out_instr, out_valid, head);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b1 || level !== 3'd3) begin
      n_bad++;
      $display("FAIL pop_release: in_ready=%b level=%0d, want 1 3", in_ready, level);
    end
    e.instr = 32'h003140B3;
    e.addr  = exp_addr;
    e.err   = 1'b0;
    sb.push_back(e);
    exp_addr = exp_addr + 8'd1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n_cmp++;
    if (level !== 3'd4) begin
      n_bad++;
      $display("FAIL held_accept: level=%0d, want 4", level);
    end
    drain();
  endtask

  task automatic test_illegal();
    logic [7:0] a;
    a = exp_addr;
    out_ready = 1'b0;
    send(OP_SUB, 1'b1, 1'b0, 5'd5, 5'd6, 5'd0, 12'h001, 32'h00000013, 1'b1);
    n_cmp++;
    if (out_instr !== 32'h00000013 || out_err !== 1'b1 || out_addr !== a) begin
      n_bad++;
      $display("FAIL illegal_head: instr=%h err=%b addr=%0d, want 00000013 1 %0d",
               out_instr, out_err, out_addr, a);
    end
    send(OP_ADD, 1'b0, 1'b0, 5'd3, 5'd1, 5'd2, 12'h000, 32'h002081B3, 1'b0);
    drain();
  endtask

  task automatic test_addr_wrap();
    for (int i = 0; i < 4; i++) begin
      in_valid2 = 1'b1;
      in_rd2    = 5'(i + 1);
      @(negedge clk);
      n_cmp++;
      if (in_ready2 !== 1'b1) begin
        n_bad++;
        $display("FAIL wrap_ready[%0d]: in_ready=%b, want 1", i, in_ready2);
      end
      @(posedge clk);
      #1;
    end
    in_valid2 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (out_valid2 !== 1'b1 || out_addr2 !== 2'(i) || out_err2 !== 1'b0 ||
          out_instr2 !== ((32'h001 << 20) | (32'(i + 1) << 7) | 32'h13)) begin
        n_bad++;
        $display("FAIL wrap_addr[%0d]: valid=%b addr=%0d err=%b instr=%h, want addr %0d",
                 i, out_valid2, out_addr2, out_err2, out_instr2, i);
      end
      out_ready2 = 1'b1;
      @(posedge clk);
      #1;
      out_ready2 = 1'b0;
    end
    in_valid2 = 1'b1;
    in_rd2    = 5'd9;
    @(posedge clk);
    #1;
    in_valid2 = 1'b0;
    n_cmp++;
    if (out_valid2 !== 1'b1 || out_addr2 !== 2'd0 || level2 !== 3'd1) begin
      n_bad++;
      $display("FAIL wrap_fifth: valid=%b addr=%0d level=%0d, want 1 0 1",
               out_valid2, out_addr2, level2);
    end
    out_ready2 = 1'b1;
    @(posedge clk);
    #1;
    out_ready2 = 1'b0;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    send(OP_OR, 1'b0, 1'b0, 5'd1, 5'd2, 5'd3, 12'h000, 32'h003160B3, 1'b0);
    send(OP_AND, 1'b0, 1'b0, 5'd1, 5'd2, 5'd3, 12'h000, 32'h003170B3, 1'b0);
    n_cmp++;
    if (level !== 3'd2) begin
      n_bad++;
      $display("FAIL mid_level: level=%0d, want 2", level);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || level !== 3'd0 || out_instr !== 32'h0 || in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_reset: valid=%b level=%0d instr=%h ready=%b, want 0 0 0 0",
               out_valid, level, out_instr, in_ready);
    end
    sb.delete();
    exp_addr = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    send(OP_SLT, 1'b0, 1'b0, 5'd1, 5'd2, 5'd3, 12'h000, 32'h003120B3, 1'b0);
    n_cmp++;
    if (out_addr !== 8'd0 || level !== 3'd1) begin
      n_bad++;
      $display("FAIL mid_after: addr=%0d level=%0d, want 0 1", out_addr, level);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_back_to_back();
    test_all_ops();
    test_full_stall();
    test_illegal();
    test_addr_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
